ps2_tx: RTL and testbench

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_defines_pkg.sv | 22 ++
 rtl/ps2_sync_filter.sv | 60 ++++++
 rtl/ps2_tx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_defines_pkg.sv
// Shared PS/2 definitions: transmit FSM encoding, frame geometry and parity helper.
// Used by both the host transmitter and the receiver.
package ps2_defines_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;  // start, 8 data, parity, stop

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_SHIFT,
    ST_STOP,
    ST_ACK,
    ST_WAIT_RELEASE
  } ps2_tx_state_t;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer for PS/2 clock and data, plus a glitch filter on the clock
// that flags filtered 1->0 transitions.
module ps2_sync_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clk_raw,
  input  logic i_data_raw,
  output logic o_clk_filt,
  output logic o_data_sync,
  output logic o_clk_fall
);

  localparam int             FW       = $clog2(FILTER_CYCLES) + 1;
  localparam logic [FW-1:0]  FLT_LAST = FW'(FILTER_CYCLES - 1);

  logic          r_clk_meta, r_clk_sync;
  logic          r_data_meta, r_data_sync;
  logic          r_clk_filt;
  logic          r_fall;
  logic [FW-1:0] r_flt_cnt;

  // NOTE: sequential state uses non-blocking assignments; the idle bus level is 1, so
  // the synchronizer and filter come out of reset high to avoid a spurious edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
      r_clk_filt  <= 1'b1;
      r_fall      <= 1'b0;
      r_flt_cnt   <= '0;
    end else begin
      r_clk_meta  <= i_clk_raw;
      r_clk_sync  <= r_clk_meta;
      r_data_meta <= i_data_raw;
      r_data_sync <= r_data_meta;
      r_fall      <= 1'b0;
      if (r_clk_sync != r_clk_filt) begin
        // The FILTER_CYCLES-th consecutive differing sample flips the level.
        if (r_flt_cnt == FLT_LAST) begin
          r_clk_filt <= r_clk_sync;
          r_fall     <= r_clk_filt;
          r_flt_cnt  <= '0;
        end else begin
          r_flt_cnt <= r_flt_cnt + FW'(1);
        end
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  assign o_clk_filt  = r_clk_filt;
  assign o_data_sync = r_data_sync;
  assign o_clk_fall  = r_fall;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, bit shifting on device
// clock falling edges, ACK check and inter-edge timeout. Lines are open-drain enables.
module ps2_tx
  import ps2_defines_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_w,
  output logic       ps2_clk_o,
  input  logic       ps2_data_i,
  output logic       ps2_data_w,
  output logic       ps2_data_o,
  input  logic       tx_en,
  input  logic       send_req,
  input  logic [7:0] send_data,
  output logic       send_done,
  output logic       send_err,
  output logic       tx_idle
);

  localparam int            IW       = $clog2(INHIBIT_CYCLES + 1);
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 2);

  logic w_clk_filt, w_data_sync, w_fall;

  ps2_sync_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_clk_raw  (ps2_clk_i),
    .i_data_raw (ps2_data_i),
    .o_clk_filt (w_clk_filt),
    .o_data_sync(w_data_sync),
    .o_clk_fall (w_fall)
  );

  ps2_tx_state_t r_state, w_state_nxt;
  logic          r_clk_w, w_clk_w_nxt;
  logic          r_data_w, w_data_w_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          r_ack_err, w_ack_err_nxt;
  logic [IW-1:0] r_inh_cnt, w_inh_cnt_nxt;
  logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
  logic [3:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [8:0]    r_shift, w_shift_nxt;
  logic          w_active;

  assign w_active = r_state inside {ST_REQUEST, ST_SHIFT, ST_STOP, ST_ACK, ST_WAIT_RELEASE};

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_w_nxt   = r_clk_w;
    w_data_w_nxt  = r_data_w;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_ack_err_nxt = r_ack_err;
    w_inh_cnt_nxt = r_inh_cnt;
    w_to_cnt_nxt  = '0;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;

    if (w_active) w_to_cnt_nxt = w_fall ? '0 : r_to_cnt + TW'(1);

    case (r_state)
      ST_IDLE: begin
        w_clk_w_nxt  = 1'b0;
        w_data_w_nxt = 1'b0;
        if (tx_en && send_req) begin
          w_shift_nxt   = {odd_parity(send_data), send_data};
          w_inh_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          w_ack_err_nxt = 1'b0;
          w_clk_w_nxt   = 1'b1;
          w_state_nxt   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        w_inh_cnt_nxt = r_inh_cnt + IW'(1);
        if (r_inh_cnt == INH_LAST) begin
          w_clk_w_nxt  = 1'b0;
          w_data_w_nxt = 1'b1;
          w_state_nxt  = ST_REQUEST;
        end else if (r_inh_cnt == INH_PRE) begin
          w_data_w_nxt = 1'b1;
        end
      end
      ST_REQUEST: begin
        if (w_fall) begin
          w_data_w_nxt  = ~r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[8:1]};
          w_bit_cnt_nxt = 4'd1;
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_fall) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_data_w_nxt = 1'b0;
            w_state_nxt  = ST_STOP;
          end else begin
            w_data_w_nxt  = ~r_shift[0];
            w_shift_nxt   = {1'b0, r_shift[8:1]};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_fall) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        // Device holds data low through the low phase of the 11th clock to ACK.
        w_ack_err_nxt = w_data_sync;
        w_state_nxt   = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (w_clk_filt && w_data_sync) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = r_ack_err;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_active && !w_fall && (r_to_cnt == TO_LAST)) begin
      w_clk_w_nxt  = 1'b0;
      w_data_w_nxt = 1'b0;
      w_done_nxt   = 1'b1;
      w_err_nxt    = 1'b1;
      w_state_nxt  = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_clk_w   <= 1'b0;
      r_data_w  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ack_err <= 1'b0;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_w   <= w_clk_w_nxt;
      r_data_w  <= w_data_w_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_ack_err <= w_ack_err_nxt;
      r_inh_cnt <= w_inh_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  assign ps2_clk_w  = r_clk_w;
  assign ps2_data_w = r_data_w;
  assign ps2_clk_o  = 1'b0;
  assign ps2_data_o = 1'b0;
  assign send_done  = r_done;
  assign send_err   = r_err;
  assign tx_idle    = (r_state == ST_IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// Testbench for ps2_tx: a PS/2 device model clocks frames out of the host and a
// scoreboard of expected frame results is checked at each send_done.
module tb_ps2_tx;

  localparam int INH  = 50;
  localparam int TO   = 2000;
  localparam int FLT  = 4;
  localparam int HALF = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_w, ps2_clk_o, ps2_data_w, ps2_data_o;
  logic       tx_en, send_req;
  logic [7:0] send_data;
  logic       send_done, send_err, tx_idle;

  // Open-drain bus: either side may pull a line low.
  assign ps2_clk_i  = dev_clk & ~ps2_clk_w;
  assign ps2_data_i = dev_data & ~ps2_data_w;

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_CYCLES (FLT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_i (ps2_clk_i),
    .ps2_clk_w (ps2_clk_w),
    .ps2_clk_o (ps2_clk_o),
    .ps2_data_i(ps2_data_i),
    .ps2_data_w(ps2_data_w),
    .ps2_data_o(ps2_data_o),
    .tx_en     (tx_en),
    .send_req  (send_req),
    .send_data (send_data),
    .send_done (send_done),
    .send_err  (send_err),
    .tx_idle   (tx_idle)
  );

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_err;
    bit         exp_par;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    bit         par;
    bit         err;
    bit         chk_bits;
  } sb_t;

  vec_t vecs [6];
  sb_t  sb [$];

  int n_total = 0, n_bad = 0;
  int frame_cnt = 0, done_cnt = 0;
  logic prev_clk_w = 1'b0;

  always @(negedge clk) begin
    prev_clk_w <= ps2_clk_w;
    if (ps2_clk_w && !prev_clk_w) frame_cnt <= frame_cnt + 1;
    if (send_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic [7:0] d);
    send_data = d;
    send_req  = 1'b1;
    @(negedge clk);
    send_req  = 1'b0;
  endtask

  task automatic measure_inhibit();
    int n = 0, nd = 0;
    check("idle_fall", tx_idle, 0);
    while (ps2_clk_w && n < INH + 20) begin
      n++;
      if (ps2_data_w) nd++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("data_final_cycle", nd, 1);
    check("data_low_at_release", ps2_data_w, 1);
  endtask

  task automatic device(input bit ack, input int n_pulses, output logic [10:0] bits);
    bits = '1;
    for (int i = 0; i < n_pulses; i++) begin
      if (i == 10 && ack) dev_data = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      bits[i] = ps2_data_i;
    end
    dev_data = 1'b1;
  endtask

  task automatic finish_frame(input logic [10:0] bits, input int budget);
    bit  got = 0;
    sb_t e;
    for (int i = 0; i < budget; i++) begin
      if (send_done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", got, 1);
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (got) begin
        check("send_err", send_err, e.err);
        if (e.chk_bits) begin
          check("data_bits", bits[7:0], e.data);
          check("parity_bit", bits[8], e.par);
          check("stop_bit", bits[9], 1);
        end
        @(negedge clk);
        check("done_one_cycle", send_done, 0);
        check("idle_after", tx_idle, 1);
      end
    end
  endtask

  task automatic run_vector(input vec_t v);
    logic [10:0] bits;
    start_req(v.data);
    sb.push_back('{v.data, v.exp_par, v.exp_err, 1'b1});
    measure_inhibit();
    device(v.ack, 11, bits);
    finish_frame(bits, 100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    int          n, f0, d0;

    vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'hF4, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hA5, 1'b0, 1'b1, 1'b1};

    send_req  = 1'b0;
    send_data = 8'h00;
    tx_en     = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_clk_w", ps2_clk_w, 0);
    check("rst_data_w", ps2_data_w, 0);
    check("rst_clk_o", ps2_clk_o, 0);
    check("rst_data_o", ps2_data_o, 0);
    check("rst_done", send_done, 0);
    check("rst_err", send_err, 0);
    check("rst_idle", tx_idle, 1);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vector(vecs[i]);

    // Device never clocks: timeout from REQUEST entry.
    start_req(8'h12);
    sb.push_back('{8'h12, 1'b1, 1'b1, 1'b0});
    measure_inhibit();
    n = 0;
    while (!send_done && n < TO + 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_window", (n >= TO - 1 && n <= TO + 1), 1);
    check("to_clk_released", ps2_clk_w, 0);
    check("to_data_released", ps2_data_w, 0);
    finish_frame('1, 10);

    // Request with tx_en low is ignored.
    f0 = frame_cnt;
    d0 = done_cnt;
    tx_en = 1'b0;
    start_req(8'h33);
    check("dis_idle", tx_idle, 1);
    repeat (100) @(negedge clk);
    check("dis_no_frame", frame_cnt - f0, 0);
    check("dis_no_done", done_cnt - d0, 0);
    tx_en = 1'b1;

    // Request during a frame is ignored; tx_en drop mid-frame does not abort.
    f0 = frame_cnt;
    d0 = done_cnt;
    start_req(8'h5A);
    sb.push_back('{8'h5A, 1'b1, 1'b0, 1'b1});
    measure_inhibit();
    fork
      device(1'b1, 11, bits);
      begin
        repeat (60) @(negedge clk);
        send_data = 8'hC3;
        send_req  = 1'b1;
        @(negedge clk);
        send_req  = 1'b0;
        tx_en     = 1'b0;
      end
    join
    finish_frame(bits, 100);
    tx_en = 1'b1;
    repeat (200) @(negedge clk);
    check("one_frame", frame_cnt - f0, 1);
    check("one_done", done_cnt - d0, 1);

    // Asynchronous reset during INHIBIT releases the clock line.
    start_req(8'h00);
    repeat (5) @(negedge clk);
    check("inh_clk_w", ps2_clk_w, 1);
    #1 rst = 1'b0;
    #1;
    check("rst_inh_clk_w", ps2_clk_w, 0);
    check("rst_inh_idle", tx_idle, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Asynchronous reset after the 4th falling edge.
    d0 = done_cnt;
    start_req(8'h00);
    measure_inhibit();
    device(1'b1, 3, bits);
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_data_w", ps2_data_w, 1);
    check("mid_busy", tx_idle, 0);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_clk_w", ps2_clk_w, 0);
    check("rst_mid_data_w", ps2_data_w, 0);
    check("rst_mid_idle", tx_idle, 1);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_no_done", done_cnt - d0, 0);

    // Normal frame after reset.
    run_vector(vecs[0]);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
